packet_summer: RTL and testbench

- AXI-Stream stage directly upstream of the NoC output sink.
- Accepts a packet of operand beats terminated by TLAST and sums the low OPW bits of each beat.
- Emits one result beat per packet; the sum is zero-extended into TDATA. The downstream sink records TDATA[8:0] as "Sum".
- Forwards the first beat's TID/TDEST and flags over-length packets.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/packet_summer.sv | 163 ++++++++++++++++
 tb/tb_packet_summer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared types and default widths for the NoC output-side
//                stream stages (packet_summer and friends).
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Default AXI-Stream field widths used by NoC stages.
    localparam int DEF_TDATAW = 32;
    localparam int DEF_TDESTW = 4;
    localparam int DEF_TIDW   = 2;

    // Packet-processing FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/packet_summer.sv
`default_nettype none
// ============================================================================
//  Module      : packet_summer
//  Description : AXI-Stream stage that sums the low OPW bits of every beat of
//                a packet (terminated by TLAST, or forcibly after MAXBEATS
//                beats) and emits one zero-extended result beat per packet.
//                The first beat's TID/TDEST travel with the result.
//  Revision    : 1.0 - initial release
//
//  Optional feature macro:
//    PACKET_SUMMER_SAT_EN - when defined the accumulator saturates at
//                           2^SUMW-1; when undefined it wraps modulo 2^SUMW.
//
//  Ports:
//    CLK, RST_N                 clock, asynchronous active-low reset
//    AXIS_S_*                   operand stream in (TDATA[OPW-1:0] used)
//    AXIS_M_*                   result stream out (one beat per packet)
//    ERR                        sticky: some packet hit MAXBEATS without TLAST
//    PKT_CNT                    results delivered, wraps at 16 bits
// ============================================================================
module packet_summer
    import noc_pkg::*;
#(
    parameter int TDATAW   = noc_pkg::DEF_TDATAW,
    parameter int TDESTW   = noc_pkg::DEF_TDESTW,
    parameter int TIDW     = noc_pkg::DEF_TIDW,
    parameter int OPW      = 8,
    parameter int SUMW     = 9,
    parameter int MAXBEATS = 16
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,

    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TIDW-1:0]   AXIS_M_TID,
    output logic [TDESTW-1:0] AXIS_M_TDEST,

    output logic              ERR,
    output logic [15:0]       PKT_CNT
);

    // Beat counter must be able to hold the value MAXBEATS itself.
    localparam int CNTW = $clog2(MAXBEATS + 1);

    state_t              state_q;
    logic [SUMW-1:0]     acc_q,  acc_d;
    logic [CNTW-1:0]     cnt_q,  cnt_d;
    logic [TIDW-1:0]     tid_q;
    logic [TDESTW-1:0]   tdest_q;
    logic                m_tvalid_q;
    logic                err_q;
    logic [15:0]         pkt_cnt_q;

    logic                w_s_tready;
    logic                w_s_hs;
    logic [SUMW-1:0]     w_opnd;
    logic [SUMW-1:0]     w_base;
    logic                w_force_end;

    // Operand bits above OPW carry no meaning for this stage.
    logic                w_unused_tdata;
    assign w_unused_tdata = ^AXIS_S_TDATA[TDATAW-1:OPW];

    // Gated by RST_N so the stage never advertises ready while held in reset.
    assign w_s_tready = (state_q != EMIT) && RST_N;
    assign w_s_hs     = AXIS_S_TVALID && w_s_tready;

    // Next accumulator and beat count for an accepted beat. In IDLE the
    // packet starts fresh, so the running sum is treated as zero.
    assign w_opnd = SUMW'(AXIS_S_TDATA[OPW-1:0]);
    assign w_base = (state_q == IDLE) ? '0 : acc_q;

`ifdef PACKET_SUMMER_SAT_EN
    logic [SUMW:0]       w_wide;
    assign w_wide = {1'b0, w_base} + {1'b0, w_opnd};
    // Operands are unsigned, so once clamped the sum stays all-ones.
    assign acc_d  = w_wide[SUMW] ? '1 : w_wide[SUMW-1:0];
`else
    assign acc_d  = w_base + w_opnd;
`endif

    assign cnt_d       = (state_q == IDLE) ? CNTW'(1) : cnt_q + 1'b1;
    assign w_force_end = (cnt_d == CNTW'(MAXBEATS));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            tid_q      <= '0;
            tdest_q    <= '0;
            m_tvalid_q <= 1'b0;
            err_q      <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_s_hs) begin
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_d;
                        tid_q   <= AXIS_S_TID;
                        tdest_q <= AXIS_S_TDEST;
                        if (AXIS_S_TLAST) begin
                            state_q    <= EMIT;
                            m_tvalid_q <= 1'b1;
                        end else begin
                            state_q    <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_s_hs) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (AXIS_S_TLAST || w_force_end) begin
                            state_q    <= EMIT;
                            m_tvalid_q <= 1'b1;
                            // Only an over-length packet is an error; TLAST on
                            // exactly the MAXBEATS-th beat is a legal packet.
                            if (!AXIS_S_TLAST) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                EMIT: begin
                    // Input is blocked here, which costs one bubble per packet.
                    if (AXIS_M_TREADY) begin
                        m_tvalid_q <= 1'b0;
                        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The accumulator holds steady throughout EMIT, so it doubles as the
    // registered result data.
    assign AXIS_S_TREADY = w_s_tready;
    assign AXIS_M_TVALID = m_tvalid_q;
    assign AXIS_M_TDATA  = TDATAW'(acc_q);
    assign AXIS_M_TLAST  = m_tvalid_q;
    assign AXIS_M_TID    = tid_q;
    assign AXIS_M_TDEST  = tdest_q;
    assign ERR           = err_q;
    assign PKT_CNT       = pkt_cnt_q;

endmodule : packet_summer
`default_nettype wire

// File: tb/tb_packet_summer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_summer
//  Description : Self-checking bench for packet_summer: reset values, a table
//                of directed packets, hand-written latency / back-pressure /
//                mid-packet reset sequences, and a randomized run checked
//                against a packet-level sum model.
//  Revision    : 1.0 - initial release
//  Macro       : PACKET_SUMMER_SAT_EN selects saturating expectations.
// ============================================================================
module tb_packet_summer;

`ifdef PACKET_SUMMER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        CLK;
    logic        RST_N;
    logic        S_TVALID;
    logic        S_TREADY;
    logic [31:0] S_TDATA;
    logic        S_TLAST;
    logic [1:0]  S_TID;
    logic [3:0]  S_TDEST;
    logic        M_TVALID;
    logic        M_TREADY;
    logic [31:0] M_TDATA;
    logic        M_TLAST;
    logic [1:0]  M_TID;
    logic [3:0]  M_TDEST;
    logic        ERR;
    logic [15:0] PKT_CNT;

    packet_summer dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .AXIS_S_TVALID (S_TVALID),
        .AXIS_S_TREADY (S_TREADY),
        .AXIS_S_TDATA  (S_TDATA),
        .AXIS_S_TLAST  (S_TLAST),
        .AXIS_S_TID    (S_TID),
        .AXIS_S_TDEST  (S_TDEST),
        .AXIS_M_TVALID (M_TVALID),
        .AXIS_M_TREADY (M_TREADY),
        .AXIS_M_TDATA  (M_TDATA),
        .AXIS_M_TLAST  (M_TLAST),
        .AXIS_M_TID    (M_TID),
        .AXIS_M_TDEST  (M_TDEST),
        .ERR           (ERR),
        .PKT_CNT       (PKT_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Expected results, consumed in order by the output monitor.
    typedef struct {
        logic [8:0] sum;
        logic [1:0] tid;
        logic [3:0] dest;
    } res_t;
    res_t exp_q[$];

    function automatic logic [8:0] fold(input int total);
        if (SAT) return (total > 511) ? 9'h1FF : total[8:0];
        else     return total[8:0];
    endfunction

    // Output monitor: a result is taken at the next rising edge whenever
    // TVALID and TREADY are both high mid-cycle.
    always @(negedge CLK) begin
        if (RST_N && M_TVALID && M_TREADY) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got TDATA 0x%0h, expected no result (t=%0t)", M_TDATA, $time);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("res_tdata", M_TDATA, {23'd0, e.sum});
                chk("res_tid",   {30'd0, M_TID}, {30'd0, e.tid});
                chk("res_tdest", {28'd0, M_TDEST}, {28'd0, e.dest});
                chk("res_tlast", {31'd0, M_TLAST}, 32'd1);
            end
        end
    end

    // Downstream ready: 0 = always low, 1 = always high, 2 = random.
    int rdy_mode = 1;
    initial begin
        M_TREADY = 1'b1;
        forever begin
            @(posedge CLK);
            #3;
            case (rdy_mode)
                0:       M_TREADY = 1'b0;
                1:       M_TREADY = 1'b1;
                default: M_TREADY = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic send_beat(input logic [31:0] d, input bit last,
                             input logic [1:0] id, input logic [3:0] dst);
        int n;
        n = 0;
        S_TVALID = 1'b1;
        S_TDATA  = d;
        S_TLAST  = last;
        S_TID    = id;
        S_TDEST  = dst;
        forever begin
            @(negedge CLK);
            if (S_TREADY) break;
            n++;
            if (n > 200) begin
                timeout_fail("send_beat");
                break;
            end
        end
        @(posedge CLK);
        #1;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(posedge CLK);
            #2;
            n++;
            if (n > budget) begin
                timeout_fail("wait_drain");
                exp_q.delete();
            end
        end
        @(posedge CLK);
        #2;
    endtask

    typedef struct {
        int          n;
        bit          last;
        logic [31:0] d0, d1, d2, fill;
        logic [1:0]  tid;
        logic [3:0]  dest;
        logic [8:0]  sum;
        bit          err;
    } vec_t;
    vec_t tbl[7];

    int   pkts;

    initial begin
        // Directed packet table: operands, sideband, expected sum and ERR.
        tbl[0] = '{2,  1'b1, 32'h12,       32'h34, 32'h0,  32'h0,  2'd1, 4'd3, 9'h046, 1'b0};
        tbl[1] = '{2,  1'b1, 32'hFF,       32'hFF, 32'h0,  32'h0,  2'd2, 4'd5, 9'h1FE, 1'b0};
        tbl[2] = '{3,  1'b1, 32'hFF,       32'hFF, 32'hFF, 32'h0,  2'd0, 4'hA,
                   (SAT ? 9'h1FF : 9'h0FD), 1'b0};
        tbl[3] = '{2,  1'b1, 32'hFFFFFF03, 32'h04, 32'h0,  32'h0,  2'd3, 4'hF, 9'h007, 1'b0};
        tbl[4] = '{1,  1'b1, 32'hA5,       32'h0,  32'h0,  32'h0,  2'd1, 4'd6, 9'h0A5, 1'b0};
        tbl[5] = '{16, 1'b0, 32'h01,       32'h01, 32'h01, 32'h01, 2'd2, 4'd9, 9'h010, 1'b1};
        tbl[6] = '{1,  1'b1, 32'h02,       32'h0,  32'h0,  32'h0,  2'd0, 4'd1, 9'h002, 1'b1};

        RST_N    = 1'b0;
        S_TVALID = 1'b0;
        S_TDATA  = '0;
        S_TLAST  = 1'b0;
        S_TID    = '0;
        S_TDEST  = '0;

        // ---- Reset values ----
        #12;
        chk("rst_s_tready", {31'd0, S_TREADY}, 32'd0);
        chk("rst_m_tvalid", {31'd0, M_TVALID}, 32'd0);
        chk("rst_m_tdata",  M_TDATA, 32'd0);
        chk("rst_m_tlast",  {31'd0, M_TLAST}, 32'd0);
        chk("rst_m_tid",    {30'd0, M_TID}, 32'd0);
        chk("rst_m_tdest",  {28'd0, M_TDEST}, 32'd0);
        chk("rst_err",      {31'd0, ERR}, 32'd0);
        chk("rst_pkt_cnt",  {16'd0, PKT_CNT}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_s_tready", {31'd0, S_TREADY}, 32'd1);
        @(posedge CLK);
        #1;

        // ---- Latency: result valid right after the TLAST accept edge ----
        exp_q.push_back('{9'h046, 2'd1, 4'd3});
        send_beat(32'h12, 1'b0, 2'd1, 4'd3);
        send_beat(32'h34, 1'b1, 2'd2, 4'd7);   // later TID/TDEST must be ignored
        chk("latency_valid", {31'd0, M_TVALID}, 32'd1);
        chk("latency_tdata", M_TDATA, 32'h046);
        wait_drain(50);
        pkts = 1;
        chk("latency_pkt_cnt", {16'd0, PKT_CNT}, 32'd1);

        // ---- Directed table ----
        for (int v = 0; v < 7; v++) begin
            exp_q.push_back('{tbl[v].sum, tbl[v].tid, tbl[v].dest});
            for (int i = 0; i < tbl[v].n; i++) begin
                logic [31:0] d;
                d = (i == 0) ? tbl[v].d0 : (i == 1) ? tbl[v].d1 :
                    (i == 2) ? tbl[v].d2 : tbl[v].fill;
                send_beat(d, tbl[v].last && (i == tbl[v].n - 1), tbl[v].tid, tbl[v].dest);
            end
            wait_drain(50);
            pkts++;
            chk($sformatf("tbl%0d_err", v), {31'd0, ERR}, {31'd0, tbl[v].err});
            chk($sformatf("tbl%0d_pkt_cnt", v), {16'd0, PKT_CNT}, pkts);
        end

        // ---- Back-pressure: result held stable, input blocked ----
        rdy_mode = 0;
        @(posedge CLK);
        #4;
        exp_q.push_back('{9'h0A5, 2'd3, 4'd2});
        send_beat(32'hA5, 1'b1, 2'd3, 4'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("bp_tvalid",   {31'd0, M_TVALID}, 32'd1);
            chk("bp_tdata",    M_TDATA, 32'h0A5);
            chk("bp_s_tready", {31'd0, S_TREADY}, 32'd0);
        end
        rdy_mode = 1;
        @(posedge CLK);
        #4;                         // TREADY now high; handshake on next edge
        @(posedge CLK);
        #1;
        chk("bp_delivered_first_ready", {31'd0, M_TVALID}, 32'd0);
        pkts++;
        chk("bp_pkt_cnt", {16'd0, PKT_CNT}, pkts);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // ---- Reset mid-packet ----
        send_beat(32'h11, 1'b0, 2'd1, 4'd1);
        send_beat(32'h22, 1'b0, 2'd1, 4'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_err",      {31'd0, ERR}, 32'd0);
        chk("midrst_pkt_cnt",  {16'd0, PKT_CNT}, 32'd0);
        chk("midrst_s_tready", {31'd0, S_TREADY}, 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        exp_q.push_back('{9'h005, 2'd2, 4'd4});
        send_beat(32'h05, 1'b1, 2'd2, 4'd4);
        wait_drain(50);
        chk("midrst_after_err",     {31'd0, ERR}, 32'd0);
        chk("midrst_after_pkt_cnt", {16'd0, PKT_CNT}, 32'd1);

        // ---- Randomized run against a packet-level model ----
        begin
            int   msum, mcnt, mpkts;
            bit   merr;
            logic [1:0] ftid;
            logic [3:0] fdest;
            msum  = 0;
            mcnt  = 0;
            mpkts = 1;
            merr  = 1'b0;
            ftid  = '0;
            fdest = '0;
            rdy_mode = 2;
            for (int b = 0; b < 300; b++) begin
                logic [31:0] d;
                logic [1:0]  id;
                logic [3:0]  dst;
                bit          last;
                d    = $urandom;
                id   = 2'($urandom);
                dst  = 4'($urandom);
                last = ($urandom_range(0, 9) == 0) || (b == 299);
                if (mcnt == 0) begin
                    ftid  = id;
                    fdest = dst;
                end
                msum += int'(d[7:0]);
                mcnt++;
                if (last || mcnt == 16) begin
                    exp_q.push_back('{fold(msum), ftid, fdest});
                    if (!last) merr = 1'b1;
                    mpkts++;
                    msum = 0;
                    mcnt = 0;
                end
                repeat ($urandom_range(0, 2)) @(posedge CLK);
                #1;
                send_beat(d, last, id, dst);
            end
            wait_drain(500);
            chk("rand_err",     {31'd0, ERR}, {31'd0, merr});
            chk("rand_pkt_cnt", {16'd0, PKT_CNT}, mpkts);
        end

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_packet_summer
`default_nettype wire
